// File: rtl/mealy_table_fsm_pkg.sv
// Shared definitions for the table-driven Mealy automaton: field-width
// helpers, the packed table-entry layout and the step-outcome encoding.
package mealy_table_fsm_pkg;

    localparam int DEF_SW = 4;
    localparam int DEF_NI = 2;
    localparam int DEF_NO = 9;

    // Width of one table payload {next_state, outputs}.
    function automatic int entry_w(input int sw, input int no);
        return sw + no;
    endfunction

    // Width of the lookup / config address {state, x}.
    function automatic int addr_w(input int sw, input int ni);
        return sw + ni;
    endfunction

    // Number of table entries: one per {state, x} combination.
    function automatic int table_depth(input int sw, input int ni);
        return 1 << (sw + ni);
    endfunction

    // Payload layout at the default widths; next_state sits in the MSBs so
    // the packed value matches the cfg_wdata / cfg_rdata bus ordering.
    typedef struct packed {
        logic [DEF_SW-1:0] next_state;
        logic [DEF_NO-1:0] out;
    } entry_t;

    // What the automaton does at the next enabled edge.
    typedef enum logic [1:0] {
        STEP_HOLD  = 2'd0,
        STEP_GO    = 2'd1,
        STEP_FAULT = 2'd2
    } step_e;

endpackage

// File: rtl/mealy_table_fsm_table_ram.sv
// Payload store for the transition table: one write port, one asynchronous
// read port for the automaton lookup and one registered read port for the
// configuration readback. Validity is tracked outside so reset can clear it.
module fsm_table_ram #(
    parameter int AW = 6,
    parameter int DW = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Write port; payloads are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered readback; returns the pre-write contents on a same-cycle write.
    always_ff @(posedge clk) begin
        rdata_b <= mem[raddr_b];
    end

    // Lookup port; sees the old entry during a same-cycle write.
    always_comb begin
        rdata_a = mem[raddr_a];
    end

endmodule

// File: rtl/mealy_table_fsm.sv
// Table-driven Mealy automaton. The transition/output table is written at
// run time through a small config port; each enabled edge looks up
// {state, x} and either follows the entry or falls back to RST_STATE and
// raises a sticky error.
//
//  state value        | meaning
//  -------------------+---------------------------------------------------
//  0 .. NS-1          | legal automaton state, table row {state, x} used
//  NS .. 2^SW-1       | illegal; t forced to 0, next enabled edge faults
//  RST_STATE          | entry point after reset and after any fault
module mealy_table_fsm
    import mealy_table_fsm_pkg::*;
#(
    parameter int SW        = 4,
    parameter int NI        = 2,
    parameter int NO        = 9,
    parameter int NS        = 11,
    parameter int RST_STATE = 0
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic [NI-1:0]    x,
    output logic [NO-1:0]    t,
    output logic [SW-1:0]    state,
    output logic             err,
    input  logic             cfg_we,
    input  logic [SW+NI-1:0] cfg_addr,
    input  logic [SW+NO-1:0] cfg_wdata,
    output logic [SW+NO-1:0] cfg_rdata
);

    localparam int AW    = addr_w(SW, NI);
    localparam int EW    = entry_w(SW, NO);
    localparam int DEPTH = table_depth(SW, NI);

    // One extra bit so NS == 2^SW is representable for the range compare.
    localparam logic [SW:0]   NS_LIM = (SW+1)'(NS);
    localparam logic [SW-1:0] RST_V  = SW'(RST_STATE);

    typedef struct packed {
        logic [SW-1:0] next_state;
        logic [NO-1:0] out;
    } ent_t;

    logic [SW-1:0] state_q, state_d;
    logic          err_q, err_d;
    logic [DEPTH-1:0] valid_q;
    logic          rd_vld_q;
    logic [AW-1:0] lk_addr;
    ent_t          lk_ent;
    logic [EW-1:0] lk_raw;
    logic [EW-1:0] cfg_raw;
    logic          usable;
    logic          next_legal;
    logic          ram_we;
    step_e         step;

    // Reset wins over a same-cycle write.
    assign ram_we  = cfg_we & ~res;
    assign lk_addr = {state_q, x};

    fsm_table_ram #(
        .AW (AW),
        .DW (EW)
    ) u_table (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (cfg_addr),
        .wdata   (cfg_wdata),
        .raddr_a (lk_addr),
        .rdata_a (lk_raw),
        .raddr_b (cfg_addr),
        .rdata_b (cfg_raw)
    );

    // Lookup decode, Mealy output and next-state selection.
    always_comb begin
        lk_ent     = ent_t'(lk_raw);
        usable     = 1'b0;
        next_legal = 1'b0;
        step       = STEP_HOLD;
        state_d    = state_q;
        err_d      = err_q;
        t          = '0;

        usable     = valid_q[lk_addr] && ({1'b0, state_q} < NS_LIM);
        next_legal = ({1'b0, lk_ent.next_state} < NS_LIM);

        if (usable) begin
            t = lk_ent.out;
        end

        if (en) begin
            step = (usable && next_legal) ? STEP_GO : STEP_FAULT;
        end

        case (step)
            STEP_GO: begin
                state_d = lk_ent.next_state;
            end
            STEP_FAULT: begin
                state_d = RST_V;
                err_d   = 1'b1;
            end
            default: begin
                state_d = state_q;
                err_d   = err_q;
            end
        endcase
    end

    // State and sticky error register; reset aborts any step in flight.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= RST_V;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Valid bits and readback qualifier; sampled before this edge's write.
    always_ff @(posedge clk) begin
        if (res) begin
            valid_q  <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= valid_q[cfg_addr];
            if (cfg_we) begin
                valid_q[cfg_addr] <= 1'b1;
            end
        end
    end

    // Invalid entries read back as zero even if a stale payload remains.
    always_comb begin
        cfg_rdata = rd_vld_q ? cfg_raw : '0;
    end

    assign state = state_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mealy_table_fsm.sv
// Bench for mealy_table_fsm: directed vector table followed by random
// traffic checked against an array-based reference of the automaton.
module tb_mealy_table_fsm;

    logic        clk;
    logic        res;
    logic        en;
    logic [1:0]  x;
    logic [8:0]  t;
    logic [3:0]  state;
    logic        err;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [12:0] cfg_wdata;
    logic [12:0] cfg_rdata;

    mealy_table_fsm dut (
        .clk       (clk),
        .res       (res),
        .en        (en),
        .x         (x),
        .t         (t),
        .state     (state),
        .err       (err),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference automaton: plain arrays indexed by state*4 + x.
    bit          m_known = 0;
    int          m_st;
    bit          m_err;
    bit          m_valid [64];
    int          m_nxt   [64];
    int          m_out   [64];
    logic [12:0] m_rd;

    logic [8:0]  t_pre;
    logic [3:0]  state_post;
    logic        err_post;
    logic [12:0] rd_post;

    typedef struct {
        logic        r;
        logic        e;
        logic [1:0]  xi;
        logic        w;
        logic [5:0]  a;
        logic [12:0] wd;
        logic        chk_t;
        logic [8:0]  exp_t;
        logic [3:0]  exp_state;
        logic        exp_err;
        logic        chk_rd;
        logic [12:0] exp_rd;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_t(input logic [1:0] xi);
        int idx;
        idx = m_st * 4 + int'(xi);
        if (m_valid[idx] && m_st < 11) return m_out[idx];
        return 0;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic [1:0] xi,
                              input logic w, input logic [5:0] a, input logic [12:0] wd);
        int idx;
        if (r) begin
            m_st    = 0;
            m_err   = 0;
            m_rd    = '0;
            m_known = 1;
            for (int i = 0; i < 64; i++) m_valid[i] = 0;
        end else if (m_known) begin
            m_rd = m_valid[a] ? {4'(m_nxt[a]), 9'(m_out[a])} : 13'd0;
            if (e) begin
                idx = m_st * 4 + int'(xi);
                if (m_valid[idx] && m_st < 11 && m_nxt[idx] < 11) begin
                    m_st = m_nxt[idx];
                end else begin
                    m_st  = 0;
                    m_err = 1;
                end
            end
            if (w) begin
                m_nxt[a]   = int'(wd[12:9]);
                m_out[a]   = int'(wd[8:0]);
                m_valid[a] = 1;
            end
        end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic apply(input logic r, input logic e, input logic [1:0] xi,
                         input logic w, input logic [5:0] a, input logic [12:0] wd);
        res = r; en = e; x = xi; cfg_we = w; cfg_addr = a; cfg_wdata = wd;
        #1;
        t_pre = t;
        if (m_known) chk("model_t", 32'(t), 32'(model_t(xi)));
        @(posedge clk);
        model_edge(r, e, xi, w, a, wd);
        #1;
        state_post = state;
        err_post   = err;
        rd_post    = cfg_rdata;
        if (m_known) begin
            chk("model_state", 32'(state), 32'(m_st));
            chk("model_err", 32'(err), 32'(m_err));
            chk("model_rdata", 32'(cfg_rdata), 32'(m_rd));
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  a;
        logic [12:0] wd;
        logic        w;

        res = 1'b1; en = 1'b0; x = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

        //            r  e  x     w  addr   wdata               chk_t t       st    err  chk_rd rd
        vecs[0]  = '{1, 0, 2'd0, 0, 6'd0,  13'd0,              0, 9'h000, 4'd0, 0, 1, 13'h0000};
        vecs[1]  = '{0, 1, 2'd1, 0, 6'd0,  13'd0,              1, 9'h000, 4'd0, 1, 0, 13'h0000};
        vecs[2]  = '{1, 0, 2'd0, 0, 6'd0,  13'd0,              1, 9'h000, 4'd0, 0, 1, 13'h0000};
        vecs[3]  = '{0, 0, 2'd0, 1, 6'd0,  {4'd3, 9'h000},     1, 9'h000, 4'd0, 0, 0, 13'h0000};
        vecs[4]  = '{0, 1, 2'd0, 1, 6'd14, {4'd5, 9'h011},     1, 9'h000, 4'd3, 0, 0, 13'h0000};
        vecs[5]  = '{0, 1, 2'd2, 0, 6'd14, 13'd0,              1, 9'h011, 4'd5, 0, 1, {4'd5, 9'h011}};
        vecs[6]  = '{0, 0, 2'd1, 1, 6'd21, {4'd12, 9'h0AA},    1, 9'h000, 4'd5, 0, 0, 13'h0000};
        vecs[7]  = '{0, 1, 2'd1, 0, 6'd21, 13'd0,              1, 9'h0AA, 4'd0, 1, 1, {4'd12, 9'h0AA}};
        vecs[8]  = '{0, 1, 2'd0, 0, 6'd0,  13'd0,              1, 9'h000, 4'd3, 1, 0, 13'h0000};
        vecs[9]  = '{0, 1, 2'd2, 0, 6'd14, 13'd0,              1, 9'h011, 4'd5, 1, 0, 13'h0000};
        vecs[10] = '{0, 0, 2'd3, 1, 6'd23, {4'd0, 9'h155},     1, 9'h000, 4'd5, 1, 1, 13'h0000};
        vecs[11] = '{0, 0, 2'd1, 0, 6'd23, 13'd0,              1, 9'h0AA, 4'd5, 1, 1, {4'd0, 9'h155}};
        vecs[12] = '{0, 0, 2'd3, 0, 6'd23, 13'd0,              1, 9'h155, 4'd5, 1, 0, 13'h0000};
        vecs[13] = '{0, 0, 2'd0, 0, 6'd23, 13'd0,              1, 9'h000, 4'd5, 1, 0, 13'h0000};
        vecs[14] = '{0, 0, 2'd2, 0, 6'd23, 13'd0,              1, 9'h000, 4'd5, 1, 0, 13'h0000};
        vecs[15] = '{0, 0, 2'd3, 0, 6'd23, 13'd0,              1, 9'h155, 4'd5, 1, 0, 13'h0000};
        vecs[16] = '{0, 0, 2'd3, 1, 6'd23, {4'd0, 9'h1FF},     1, 9'h155, 4'd5, 1, 1, {4'd0, 9'h155}};
        vecs[17] = '{0, 0, 2'd3, 0, 6'd23, 13'd0,              1, 9'h1FF, 4'd5, 1, 1, {4'd0, 9'h1FF}};
        vecs[18] = '{0, 1, 2'd3, 0, 6'd23, 13'd0,              1, 9'h1FF, 4'd0, 1, 0, 13'h0000};
        vecs[19] = '{0, 1, 2'd0, 0, 6'd0,  13'd0,              1, 9'h000, 4'd3, 1, 0, 13'h0000};
        vecs[20] = '{1, 1, 2'd2, 1, 6'd40, {4'd1, 9'h123},     1, 9'h011, 4'd0, 0, 1, 13'h0000};
        vecs[21] = '{0, 0, 2'd0, 0, 6'd40, 13'd0,              1, 9'h000, 4'd0, 0, 1, 13'h0000};
        vecs[22] = '{0, 0, 2'd2, 0, 6'd14, 13'd0,              1, 9'h000, 4'd0, 0, 1, 13'h0000};

        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            apply(vecs[i].r, vecs[i].e, vecs[i].xi, vecs[i].w, vecs[i].a, vecs[i].wd);
            if (vecs[i].chk_t) chk($sformatf("tbl%0d_t", i), 32'(t_pre), 32'(vecs[i].exp_t));
            chk($sformatf("tbl%0d_state", i), 32'(state_post), 32'(vecs[i].exp_state));
            chk($sformatf("tbl%0d_err", i), 32'(err_post), 32'(vecs[i].exp_err));
            if (vecs[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), 32'(rd_post), 32'(vecs[i].exp_rd));
        end

        // Random traffic against the reference model.
        apply(1'b1, 1'b0, 2'd0, 1'b0, 6'd0, 13'd0);
        for (int c = 0; c < 800; c++) begin
            logic [1:0] xr;
            xr = 2'($urandom_range(0, 3));
            w  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) a = {4'(m_st), xr};
            else                          a = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) wd[12:9] = 4'($urandom_range(0, 15));
            else                          wd[12:9] = 4'($urandom_range(0, 10));
            wd[8:0] = 9'($urandom_range(0, 511));
            apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), xr, w, a, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
